// File: rtl/bmem_arbiter.sv
// bmem_arbiter: shares one banked-memory port between an I-cache (line reads)
// and a D-cache (line reads and write-backs). One memory transaction is in
// flight at a time. Ties go to the requester that was not granted last.
// Write lines are streamed out one 64-bit beat at a time. Read beats are
// gathered into a shared line buffer, and the owner gets a one-cycle response.

module bmem_arbiter #(
  parameter int BEATS = 4
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  i_req,
  input  logic [31:0]           i_addr,
  output logic                  i_resp,
  output logic [BEATS*64-1:0]   i_rdata,

  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [31:0]           d_addr,
  input  logic [BEATS*64-1:0]   d_wdata,
  output logic                  d_resp,
  output logic [BEATS*64-1:0]   d_rdata,

  output logic [31:0]           bmem_addr,
  output logic                  bmem_read,
  output logic                  bmem_write,
  output logic [63:0]           bmem_wdata,
  input  logic                  bmem_ready,
  input  logic [31:0]           bmem_raddr,
  input  logic [63:0]           bmem_rdata,
  input  logic                  bmem_rvalid
);

  localparam int              KW     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [KW-1:0]   K_LAST = KW'(BEATS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ_REQ,
    ST_READ_WAIT,
    ST_RESP
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  state_t                  r_state;
  owner_t                  r_owner;
  owner_t                  r_last_grant;
  logic [31:0]             r_addr;
  logic [KW-1:0]           r_k;
  logic [BEATS-1:0][63:0]  r_line;
  logic                    r_read;
  logic                    r_write;
  logic [63:0]             r_wdata;
  logic                    r_i_resp;
  logic                    r_d_resp;

  logic                    w_grant_any;
  logic                    w_grant_d;
  logic                    w_grant_wr;
  logic [KW-1:0]           w_k_next;
  logic                    w_beat_hit;

  // On a tie, D wins unless D was the last requester granted.
  assign w_grant_any = i_req | d_req;
  assign w_grant_d   = d_req & (~i_req | (r_last_grant == OWN_I));
  assign w_grant_wr  = w_grant_d & d_we;
  assign w_k_next    = r_k + KW'(1);
  // A beat is accepted only if it is valid and carries our line address.
  assign w_beat_hit  = bmem_rvalid & (bmem_raddr == r_addr);

  // Arbitration and transaction FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_owner      <= OWN_I;
      r_last_grant <= OWN_I;
      r_addr       <= '0;
      r_k          <= '0;
      // NOTE: the line buffer is cleared in reset so that both rdata outputs read 0 out of reset.
      r_line       <= '0;
      r_read       <= 1'b0;
      r_write      <= 1'b0;
      r_wdata      <= '0;
      r_i_resp     <= 1'b0;
      r_d_resp     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout; every branch sees the pre-edge state.
      r_i_resp <= 1'b0;
      r_d_resp <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (w_grant_any) begin
            r_owner      <= w_grant_d ? OWN_D : OWN_I;
            r_last_grant <= w_grant_d ? OWN_D : OWN_I;
            r_addr       <= w_grant_d ? d_addr : i_addr;
            r_k          <= '0;
            if (w_grant_wr) begin
              r_line  <= d_wdata;
              r_wdata <= d_wdata[63:0];
              r_write <= 1'b1;
              r_state <= ST_WRITE;
            end else begin
              r_read  <= 1'b1;
              r_state <= ST_READ_REQ;
            end
          end
        end

        ST_WRITE: begin
          if (bmem_ready) begin
            if (r_k == K_LAST) begin
              r_write  <= 1'b0;
              r_wdata  <= '0;
              r_i_resp <= (r_owner == OWN_I);
              r_d_resp <= (r_owner == OWN_D);
              r_state  <= ST_RESP;
            end else begin
              r_k     <= w_k_next;
              r_wdata <= r_line[w_k_next];
            end
          end
        end

        ST_READ_REQ: begin
          if (bmem_ready) begin
            r_read  <= 1'b0;
            r_state <= ST_READ_WAIT;
          end
        end

        ST_READ_WAIT: begin
          if (w_beat_hit) begin
            r_line[r_k] <= bmem_rdata;
            if (r_k == K_LAST) begin
              r_i_resp <= (r_owner == OWN_I);
              r_d_resp <= (r_owner == OWN_D);
              r_state  <= ST_RESP;
            end else begin
              r_k <= w_k_next;
            end
          end
        end

        ST_RESP: begin
          r_k     <= '0;
          r_state <= ST_IDLE;
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign i_resp     = r_i_resp;
  assign d_resp     = r_d_resp;
  assign i_rdata    = r_line;
  assign d_rdata    = r_line;
  assign bmem_addr  = r_addr;
  assign bmem_read  = r_read;
  assign bmem_write = r_write;
  assign bmem_wdata = r_wdata;

endmodule

// File: tb/tb_bmem_arbiter.sv
// tb_bmem_arbiter: directed stimulus with a response scoreboard, a memory model
// that checks commands and write beats, and a response monitor.

module tb_bmem_arbiter;

  localparam int BEATS = 4;
  localparam int LW    = BEATS * 64;

  logic           clk = 1'b0;
  logic           rst;
  logic           i_req;
  logic [31:0]    i_addr;
  logic           i_resp;
  logic [LW-1:0]  i_rdata;
  logic           d_req;
  logic           d_we;
  logic [31:0]    d_addr;
  logic [LW-1:0]  d_wdata;
  logic           d_resp;
  logic [LW-1:0]  d_rdata;
  logic [31:0]    bmem_addr;
  logic           bmem_read;
  logic           bmem_write;
  logic [63:0]    bmem_wdata;
  logic           bmem_ready;
  logic [31:0]    bmem_raddr;
  logic [63:0]    bmem_rdata;
  logic           bmem_rvalid;

  always #5 clk = ~clk;

  bmem_arbiter #(.BEATS(BEATS)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_req       (i_req),
    .i_addr      (i_addr),
    .i_resp      (i_resp),
    .i_rdata     (i_rdata),
    .d_req       (d_req),
    .d_we        (d_we),
    .d_addr      (d_addr),
    .d_wdata     (d_wdata),
    .d_resp      (d_resp),
    .d_rdata     (d_rdata),
    .bmem_addr   (bmem_addr),
    .bmem_read   (bmem_read),
    .bmem_write  (bmem_write),
    .bmem_wdata  (bmem_wdata),
    .bmem_ready  (bmem_ready),
    .bmem_raddr  (bmem_raddr),
    .bmem_rdata  (bmem_rdata),
    .bmem_rvalid (bmem_rvalid)
  );

  typedef struct {
    bit            is_d;
    bit            is_rd;
    logic [LW-1:0] line;
  } resp_t;

  typedef struct {
    logic [31:0] addr;
    logic [63:0] data;
  } wbeat_t;

  resp_t       exp_resp[$];
  wbeat_t      exp_wb[$];
  logic [31:0] exp_rd_addr[$];

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int n_resp = 0;

  // memory model state
  int          stall_left   = 0;
  int          wcount       = 0;
  bit          rd_pending   = 0;
  logic [31:0] rd_addr      = '0;
  int          rd_beat      = 0;
  int          rd_delay     = 0;
  bit          stray_en     = 0;
  bit          stray_done   = 0;
  int          beats_driven = 0;
  int          last_evt     = -100;
  bit          rd_acc_prev  = 0;
  bit          wr_done_prev = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic flag_fail(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s", name);
  endtask

  // Memory contents: beat k of a line is (k+1) * 0x1111.. with the address folded in.
  function automatic logic [63:0] beat_data(input logic [31:0] a, input int k);
    return (64'h1111_1111_1111_1111 * 64'(k + 1)) ^ {32'h0, a ^ 32'h6000_0040};
  endfunction

  function automatic logic [LW-1:0] line_of(input logic [31:0] a);
    logic [LW-1:0] l;
    l = '0;
    for (int k = 0; k < BEATS; k++) l[64*k +: 64] = beat_data(a, k);
    return l;
  endfunction

  function automatic void push_read(input bit is_d, input logic [31:0] a, input logic [LW-1:0] line);
    resp_t r;
    r.is_d  = is_d;
    r.is_rd = 1'b1;
    r.line  = line;
    exp_rd_addr.push_back(a);
    exp_resp.push_back(r);
  endfunction

  // Banked-memory model: decides ready for the coming edge, checks accepted
  // commands against the expected queues, and returns read beats.
  initial begin
    bmem_ready  = 1'b1;
    bmem_rvalid = 1'b0;
    bmem_raddr  = '0;
    bmem_rdata  = '0;
    forever begin
      @(negedge clk);
      bmem_rvalid = 1'b0;
      bmem_raddr  = '0;
      bmem_rdata  = '0;

      if (rd_acc_prev) check("bmem_read drops after accept", bmem_read, 1'b0);
      rd_acc_prev = 0;
      if (wr_done_prev) check("bmem_write drops after last beat", bmem_write, 1'b0);
      wr_done_prev = 0;

      if (bmem_read) begin
        bmem_ready = 1'b1;
        if (exp_rd_addr.size() == 0) flag_fail("unexpected bmem_read");
        else check("read addr", bmem_addr, exp_rd_addr.pop_front());
        rd_pending  = 1;
        rd_addr     = bmem_addr;
        rd_beat     = 0;
        rd_delay    = 1;
        stray_done  = 0;
        rd_acc_prev = 1;
      end else if (bmem_write) begin
        if (wcount == 1 && stall_left > 0) begin
          bmem_ready = 1'b0;
          stall_left--;
          if (exp_wb.size() != 0) check("write beat held in stall", bmem_wdata, exp_wb[0].data);
        end else begin
          bmem_ready = 1'b1;
          if (exp_wb.size() == 0) flag_fail("unexpected write beat");
          else begin
            wbeat_t w;
            w = exp_wb.pop_front();
            check("write addr", bmem_addr, w.addr);
            check("write beat", bmem_wdata, w.data);
          end
          wcount++;
          if (wcount == BEATS) begin
            wcount       = 0;
            last_evt     = cyc + 1;
            wr_done_prev = 1;
          end
        end
      end else begin
        bmem_ready = 1'b1;
      end

      if (rd_pending) begin
        if (rd_delay > 0) rd_delay--;
        else if (stray_en && rd_beat == 2 && !stray_done) begin
          bmem_rvalid = 1'b1;
          bmem_raddr  = rd_addr ^ 32'h0000_1000;
          bmem_rdata  = 64'hDEAD_BEEF_DEAD_BEEF;
          stray_done  = 1;
        end else begin
          bmem_rvalid = 1'b1;
          bmem_raddr  = rd_addr;
          bmem_rdata  = beat_data(rd_addr, rd_beat);
          rd_beat++;
          beats_driven++;
          if (rd_beat == BEATS) begin
            rd_pending = 0;
            last_evt   = cyc + 1;
          end
        end
      end
    end
  end

  // Response monitor: pops the scoreboard whenever a response is presented.
  initial begin
    resp_t         e;
    logic [LW-1:0] got;
    forever begin
      @(negedge clk);
      if (rst && (i_resp || d_resp)) begin
        check("only one resp", i_resp & d_resp, 1'b0);
        if (exp_resp.size() == 0) flag_fail("unexpected resp");
        else begin
          e = exp_resp.pop_front();
          check("resp owner", d_resp, e.is_d);
          check("resp one cycle after last beat", cyc, last_evt);
          if (e.is_rd) begin
            got = e.is_d ? d_rdata : i_rdata;
            check("resp line data", got, e.line);
          end
        end
        n_resp++;
      end
    end
  end

  // Wait for the wanted responses, dropping each req once its resp is seen.
  task automatic wait_resp(input bit want_i, input bit want_d, input string name, output int ncyc);
    bit got_i = !want_i;
    bit got_d = !want_d;
    ncyc = 0;
    while (!(got_i && got_d) && ncyc < 300) begin
      @(negedge clk);
      ncyc++;
      if (want_i && i_resp) begin got_i = 1; i_req = 1'b0; end
      if (want_d && d_resp) begin got_d = 1; d_req = 1'b0; end
    end
    if (!(got_i && got_d)) begin
      flag_fail({name, " timeout waiting for resp"});
      i_req = 1'b0;
      d_req = 1'b0;
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, " bmem_read"},  bmem_read,  1'b0);
    check({tag, " bmem_write"}, bmem_write, 1'b0);
    check({tag, " bmem_addr"},  bmem_addr,  32'h0);
    check({tag, " bmem_wdata"}, bmem_wdata, 64'h0);
    check({tag, " i_resp"},     i_resp,     1'b0);
    check({tag, " d_resp"},     d_resp,     1'b0);
    check({tag, " i_rdata"},    i_rdata,    '0);
    check({tag, " d_rdata"},    d_rdata,    '0);
  endtask

  initial begin
    int     ncyc;
    int     start_resp;
    int     guard;
    resp_t  r;
    wbeat_t w;

    rst     = 1'b0;
    i_req   = 1'b0;
    i_addr  = '0;
    d_req   = 1'b0;
    d_we    = 1'b0;
    d_addr  = '0;
    d_wdata = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b1;
    @(negedge clk);

    // Simultaneous first requests: D wins the first tie, then I
    d_addr = 32'h6000_0300;
    i_addr = 32'h6000_0200;
    push_read(1'b1, 32'h6000_0300, line_of(32'h6000_0300));
    push_read(1'b0, 32'h6000_0200, line_of(32'h6000_0200));
    d_req = 1'b1;
    i_req = 1'b1;
    wait_resp(1'b1, 1'b1, "first tie", ncyc);

    // I-only read with literal beat values
    @(negedge clk);
    i_addr = 32'h6000_0040;
    push_read(1'b0, 32'h6000_0040,
              256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111);
    i_req = 1'b1;
    wait_resp(1'b1, 1'b0, "i read", ncyc);

    // D write-back, ready low for two cycles on the second beat
    @(negedge clk);
    stall_left = 2;
    d_we    = 1'b1;
    d_addr  = 32'h6000_0100;
    d_wdata = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
               64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
    w.addr = 32'h6000_0100; w.data = 64'hAAAA_AAAA_AAAA_AAAA; exp_wb.push_back(w);
    w.addr = 32'h6000_0100; w.data = 64'hBBBB_BBBB_BBBB_BBBB; exp_wb.push_back(w);
    w.addr = 32'h6000_0100; w.data = 64'hCCCC_CCCC_CCCC_CCCC; exp_wb.push_back(w);
    w.addr = 32'h6000_0100; w.data = 64'hDDDD_DDDD_DDDD_DDDD; exp_wb.push_back(w);
    r.is_d = 1'b1; r.is_rd = 1'b0; r.line = '0;
    exp_resp.push_back(r);
    d_req = 1'b1;
    wait_resp(1'b0, 1'b1, "d write stall", ncyc);
    check("stalled write latency", ncyc, BEATS + 3);

    // D write-back with ready held high: minimum latency
    @(negedge clk);
    d_addr  = 32'h6000_0180;
    d_wdata = {64'h0404_0404_0404_0404, 64'h0303_0303_0303_0303,
               64'h0202_0202_0202_0202, 64'h0101_0101_0101_0101};
    w.addr = 32'h6000_0180; w.data = 64'h0101_0101_0101_0101; exp_wb.push_back(w);
    w.addr = 32'h6000_0180; w.data = 64'h0202_0202_0202_0202; exp_wb.push_back(w);
    w.addr = 32'h6000_0180; w.data = 64'h0303_0303_0303_0303; exp_wb.push_back(w);
    w.addr = 32'h6000_0180; w.data = 64'h0404_0404_0404_0404; exp_wb.push_back(w);
    exp_resp.push_back(r);
    d_req = 1'b1;
    wait_resp(1'b0, 1'b1, "d write fast", ncyc);
    check("write min latency", ncyc, BEATS + 1);
    d_we = 1'b0;

    // I read with a stray beat between beats 1 and 2
    @(negedge clk);
    stray_en = 1;
    i_addr = 32'h6000_0400;
    push_read(1'b0, 32'h6000_0400, line_of(32'h6000_0400));
    i_req = 1'b1;
    wait_resp(1'b1, 1'b0, "stray read", ncyc);
    stray_en = 0;

    // Second simultaneous pair after an I grant: D then I
    @(negedge clk);
    d_addr = 32'h6000_0500;
    i_addr = 32'h6000_0600;
    push_read(1'b1, 32'h6000_0500, line_of(32'h6000_0500));
    push_read(1'b0, 32'h6000_0600, line_of(32'h6000_0600));
    d_req = 1'b1;
    i_req = 1'b1;
    wait_resp(1'b1, 1'b1, "second tie", ncyc);

    // Continuous requests from both sides: six alternating grants
    @(negedge clk);
    d_addr = 32'h6000_0800;
    i_addr = 32'h6000_0700;
    for (int t = 0; t < 3; t++) begin
      push_read(1'b1, 32'h6000_0800, line_of(32'h6000_0800));
      push_read(1'b0, 32'h6000_0700, line_of(32'h6000_0700));
    end
    start_resp = n_resp;
    d_req = 1'b1;
    i_req = 1'b1;
    guard = 0;
    while (n_resp - start_resp < 6 && guard < 600) begin
      @(negedge clk);
      #1;
      guard++;
    end
    i_req = 1'b0;
    d_req = 1'b0;
    check("continuous resp count", n_resp - start_resp, 6);

    // Reset during READ_WAIT after two beats
    @(negedge clk);
    beats_driven = 0;
    i_addr = 32'h6000_0900;
    exp_rd_addr.push_back(32'h6000_0900);
    i_req = 1'b1;
    guard = 0;
    while (beats_driven < 3 && guard < 100) begin
      @(negedge clk);
      #1;
      guard++;
    end
    if (beats_driven < 3) flag_fail("mid-read reset: beats never arrived");
    rst   = 1'b0;
    i_req = 1'b0;
    @(negedge clk);
    check_outputs_zero("mid-read reset");
    #1;
    rst = 1'b1;
    repeat (6) @(negedge clk);
    check("aborted read left no resp", exp_resp.size(), 0);

    // A fresh request after the abort completes normally
    i_addr = 32'h6000_0A00;
    push_read(1'b0, 32'h6000_0A00, line_of(32'h6000_0A00));
    i_req = 1'b1;
    wait_resp(1'b1, 1'b0, "post-reset read", ncyc);

    repeat (4) @(negedge clk);
    check("resp scoreboard drained", exp_resp.size(), 0);
    check("write beats drained", exp_wb.size(), 0);
    check("read cmds drained", exp_rd_addr.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
